// File: rtl/register_port_arbiter.sv
// Round-robin arbiter sharing the single axi_slave_impl register port among NUM_REQUESTERS clients.
// Each access holds the port for ACCESS_HOLD_CYCLES cycles, then issues a one-cycle ack to the owner.
module register_port_arbiter #(
  parameter int NUM_REQUESTERS     = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int REG_NUMBER_WIDTH   = 8,
  parameter int ACCESS_HOLD_CYCLES = 2
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [NUM_REQUESTERS-1:0]              req,
  input  logic [2*NUM_REQUESTERS-1:0]            req_operation,
  input  logic [REG_NUMBER_WIDTH*NUM_REQUESTERS-1:0] req_number,
  input  logic [DATA_WIDTH*NUM_REQUESTERS-1:0]   req_write_data,
  output logic [NUM_REQUESTERS-1:0]              grant,
  output logic [NUM_REQUESTERS-1:0]              ack,
  output logic [DATA_WIDTH-1:0]                  read_data,
  output logic [1:0]                             register_operation,
  output logic [REG_NUMBER_WIDTH-1:0]            register_number,
  output logic [DATA_WIDTH-1:0]                  register_write,
  input  logic [DATA_WIDTH-1:0]                  register_read,
  output logic                                   busy
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CNT_W = $clog2(ACCESS_HOLD_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_REQUESTERS-1:0]     grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0]     ack_q, ack_d;
  logic [DATA_WIDTH-1:0]         read_data_q, read_data_d;
  logic [1:0]                    reg_op_q, reg_op_d;
  logic [REG_NUMBER_WIDTH-1:0]   reg_num_q, reg_num_d;
  logic [DATA_WIDTH-1:0]         reg_wr_q, reg_wr_d;

  logic       found;
  int         win;
  int         idx;
  logic [1:0] win_op;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    read_data_d = read_data_q;
    reg_op_d    = reg_op_q;
    reg_num_d   = reg_num_q;
    reg_wr_d    = reg_wr_q;
    found       = 1'b0;
    win         = 0;
    idx         = 0;

    // Search starts at the pointer and wraps, so the last winner has lowest priority.
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQUESTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_op = req_operation[2*win +: 2];

    case (state_q)
      IDLE: begin
        ack_d = '0;
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          reg_op_d     = (win_op == 2'd1 || win_op == 2'd2) ? win_op : 2'd0;
          reg_num_d    = req_number[REG_NUMBER_WIDTH*win +: REG_NUMBER_WIDTH];
          reg_wr_d     = (win_op == 2'd2) ? req_write_data[DATA_WIDTH*win +: DATA_WIDTH] : '0;
          cnt_d        = '0;
          ptr_d        = PTR_W'((win + 1) % NUM_REQUESTERS);
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          // reg_op_q is 1 only for a genuine read; no-ops and writes return zero.
          read_data_d = (reg_op_q == 2'd1) ? register_read : '0;
          ack_d       = grant_q;
          grant_d     = '0;
          reg_op_d    = 2'd0;
          reg_num_d   = '0;
          reg_wr_d    = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ack_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      read_data_q <= '0;
      reg_op_q    <= 2'd0;
      reg_num_q   <= '0;
      reg_wr_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      read_data_q <= read_data_d;
      reg_op_q    <= reg_op_d;
      reg_num_q   <= reg_num_d;
      reg_wr_q    <= reg_wr_d;
    end
  end

  assign grant              = grant_q;
  assign ack                = ack_q;
  assign read_data          = read_data_q;
  assign register_operation = reg_op_q;
  assign register_number    = reg_num_q;
  assign register_write     = reg_wr_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_register_port_arbiter.sv
// Directed bench for register_port_arbiter with two clients and a two-cycle hold.
module tb_register_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  req_operation;
  logic [15:0] req_number;
  logic [63:0] req_write_data;
  logic [1:0]  grant;
  logic [1:0]  ack;
  logic [31:0] read_data;
  logic [1:0]  register_operation;
  logic [7:0]  register_number;
  logic [31:0] register_write;
  logic [31:0] register_read;
  logic        busy;

  int total;
  int bad;

  logic [1:0] exp_g [16];
  logic [1:0] exp_a [16];

  register_port_arbiter #(
    .NUM_REQUESTERS(2), .DATA_WIDTH(32), .REG_NUMBER_WIDTH(8), .ACCESS_HOLD_CYCLES(2)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .req(req), .req_operation(req_operation),
    .req_number(req_number), .req_write_data(req_write_data), .grant(grant), .ack(ack),
    .read_data(read_data), .register_operation(register_operation),
    .register_number(register_number), .register_write(register_write),
    .register_read(register_read), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_client(input int c, input logic [1:0] op, input logic [7:0] num,
                            input logic [31:0] wd);
    req_operation[2*c +: 2] = op;
    req_number[8*c +: 8]    = num;
    req_write_data[32*c +: 32] = wd;
  endtask

  // One full access by client c from IDLE, with hand-computed port and result values.
  task automatic access(input string tag, input int c, input logic [1:0] op,
                        input logic [7:0] num, input logic [31:0] wd, input logic [31:0] rr,
                        input logic [1:0] exp_op, input logic [31:0] exp_wr,
                        input logic [31:0] exp_rd);
    logic [1:0] oh;
    oh = 2'b01 << c;
    set_client(c, op, num, wd);
    register_read = rr;
    req[c] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check({tag, "_grant"}, 32'(grant), 32'(oh));
      check({tag, "_op"}, 32'(register_operation), 32'(exp_op));
      check({tag, "_num"}, 32'(register_number), 32'(num));
      check({tag, "_wr"}, register_write, exp_wr);
      check({tag, "_ack_low"}, 32'(ack), 32'd0);
    end
    step();
    check({tag, "_ack"}, 32'(ack), 32'(oh));
    check({tag, "_grant_off"}, 32'(grant), 32'd0);
    check({tag, "_op_off"}, 32'(register_operation), 32'd0);
    check({tag, "_rd"}, read_data, exp_rd);
    req[c] = 1'b0;
    step();
    check({tag, "_ack_off"}, 32'(ack), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_rd_hold"}, read_data, exp_rd);
    $display("access %s client=%0d op=%0d num=%0d read_data=0x%0h", tag, c, op, num, read_data);
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_g = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00,
              2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    exp_a = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00,
              2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    rst_n = 1'b0;
    req = 2'b00;
    req_operation = '0;
    req_number = '0;
    req_write_data = '0;
    register_read = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rd", read_data, 32'd0);
    check("rst_op", 32'(register_operation), 32'd0);
    check("rst_wr", register_write, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    access("t1_read", 0, 2'd1, 8'd10, 32'hAAAA_5555, 32'd96, 2'd1, 32'd0, 32'd96);
    access("t2_write", 1, 2'd2, 8'd3, 32'h1234, 32'hDEAD_BEEF, 2'd2, 32'h1234, 32'd0);

    // Owner changes number and operation mid-HOLD; latched values must survive.
    set_client(0, 2'd1, 8'd10, 32'd0);
    register_read = 32'h0BAD_F00D;
    req[0] = 1'b1;
    step();
    check("t6_num_first", 32'(register_number), 32'd10);
    set_client(0, 2'd2, 8'd12, 32'h7777);
    step();
    check("t6_num_held", 32'(register_number), 32'd10);
    check("t6_op_held", 32'(register_operation), 32'd1);
    check("t6_wr_held", register_write, 32'd0);
    step();
    check("t6_ack", 32'(ack), 32'd1);
    check("t6_rd", read_data, 32'h0BAD_F00D);
    req[0] = 1'b0;
    step();
    $display("access t6_latch client=0 number=%0d read_data=0x%0h", 10, read_data);

    access("t5_noop", 0, 2'd3, 8'd20, 32'h9999, 32'h55, 2'd0, 32'd0, 32'd0);

    // Pointer now favours client 1; both request continuously.
    set_client(0, 2'd1, 8'd1, 32'd0);
    set_client(1, 2'd1, 8'd2, 32'd0);
    register_read = 32'h42;
    req = 2'b11;
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("t3_grant_c%0d", k), 32'(grant), 32'(exp_g[k]));
      check($sformatf("t3_ack_c%0d", k), 32'(ack), 32'(exp_a[k]));
      check($sformatf("t3_onehot_c%0d", k), 32'($countones(grant) <= 1), 32'd1);
      $display("rr cycle=%0d grant=%b ack=%b", k, grant, ack);
    end

    // Client 1 wins next; reset lands in its HOLD.
    step();
    check("t4_pre_grant", 32'(grant), 32'b10);
    #1;
    rst_n = 1'b0;
    #1;
    check("t4_rst_grant", 32'(grant), 32'd0);
    check("t4_rst_op", 32'(register_operation), 32'd0);
    check("t4_rst_num", 32'(register_number), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_rd", read_data, 32'd0);
    step();
    check("t4_rst_ack", 32'(ack), 32'd0);
    step();
    check("t4_rst_ack2", 32'(ack), 32'd0);
    rst_n = 1'b1;
    step();
    check("t4_first_after_rst", 32'(grant), 32'b01);
    check("t4_busy", 32'(busy), 32'd1);
    $display("reset abort: first grant after release=%b", grant);
    req = 2'b00;
    step();
    step();
    check("t4_ack0", 32'(ack), 32'b01);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
